mips_mem_arbiter: RTL and testbench
===================================

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of consecutive stalled bus cycles, range 1..65535, before a transaction is aborted.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 clk_enable  input  1  SHALL freeze all state when low.
REQ-005 instr_read  input  1 / instr_address  input  32 / instr_readdata  output  32 / instr_waitrequest  output  1  SHALL form the fetch port, read-only.
REQ-006 data_read  input  1 / data_write  input  1 / data_address  input  32 / data_writedata  input  32 / data_byteenable  input  4 / data_readdata  output  32 / data_waitrequest  output  1  SHALL form the load/store port.
REQ-007 mem_address  output  32 / mem_read  output  1 / mem_write  output  1 / mem_writedata  output  32 / mem_byteenable  output  4 / mem_readdata  input  32 / mem_waitrequest  input  1  SHALL form the shared memory bus.
REQ-008 busy  output  1 / timeout_err  output  1  SHALL flag a granted transaction and a sticky abort, respectively.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT_I and GRANT_D.
REQ-010 A port request SHALL be defined as instr_read, or data_read|data_write, held high until that port's waitrequest is sampled low.
REQ-011 In IDLE with any request and clk_enable high, the next edge SHALL register address, byteenable (4'hF for fetch), writedata and strobes onto mem_*, and enter the matching GRANT state.
REQ-012 All mem_* outputs SHALL be registered and held constant throughout a GRANT state; in IDLE, mem_read and mem_write SHALL be 0.
REQ-013 A data port with both data_read and data_write high SHALL be issued as a write only.
REQ-014 Completion SHALL occur in the GRANT cycle where mem_waitrequest is 0: the granted port's waitrequest is 0 combinationally and its readdata equals mem_readdata in that cycle.
REQ-015 A requesting port that is not granted SHALL see waitrequest=1; a non-requesting port SHALL see waitrequest=0 and readdata=0.
REQ-016 Minimum transaction latency SHALL be 2 cycles: the request cycle in IDLE plus one GRANT cycle.
REQ-017 On the completion edge, if the other port is requesting it SHALL be granted directly (no IDLE bubble); otherwise the FSM returns to IDLE; the just-completed port SHALL NOT be re-granted on that edge.
REQ-018 Simultaneous requests in IDLE SHALL be resolved per REQ-027/REQ-028.
REQ-019 A 16-bit stall counter SHALL clear on grant and increment each GRANT cycle with mem_waitrequest=1.
REQ-020 When the counter reaches TIMEOUT_CYCLES, the transaction SHALL complete with readdata=32'hFFFF_FFFF, timeout_err SHALL set (sticky), and mem strobes SHALL drop on the next edge.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 With clk_enable low: no state, counter or mem_* change, and completions SHALL NOT be acknowledged (both waitrequests 1 for requesting ports).

Reset
REQ-023 Reset assertion SHALL, asynchronously, force state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, counter=0, timeout_err=0 and last_grant=instr.
REQ-024 Reset mid-transaction SHALL abandon the transaction without acknowledgement to either port.
REQ-025 After reset deassertion, the first grant SHALL occur on the first clk_enable-high edge with a request pending.
REQ-026 timeout_err SHALL clear only on reset.

Configuration
REQ-027 With MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted last (last_grant register) SHALL win; last_grant updates on each grant.
REQ-028 Without MEM_ARB_ROUND_ROBIN_EN: the data port SHALL always win simultaneous requests; the last_grant register SHALL be omitted.

Verification
REQ-029 Instruction read of 0xBFC0_0000 alone, mem_waitrequest=0 -> mem_read=1 next cycle, instr_waitrequest=0 in that cycle, instr_readdata=mem_readdata, then IDLE.
REQ-030 Simultaneous fetch and data write (addr 0x1000, data 0xDEAD_BEEF, be 4'b0011) -> the write is issued first with mem_write=1 and mem_byteenable=4'b0011; the fetch is granted on the completion edge with no bubble (default build).
REQ-031 MEM_ARB_ROUND_ROBIN_EN, both ports requesting continuously for 6 transactions -> grants alternate D,I,D,I,D,I starting with data (last_grant=instr after reset).
REQ-032 TIMEOUT_CYCLES=4, mem_waitrequest held 1 -> data_waitrequest=0 in the 4th stalled cycle, data_readdata=0xFFFF_FFFF, timeout_err=1 and remains 1.
REQ-033 Reset pulsed low during GRANT_D with mem_waitrequest=1 -> mem_write/mem_read=0 immediately (asynchronously), busy=0, no acknowledgement issued.
REQ-034 clk_enable low for 3 cycles during a grant with mem_waitrequest=0 -> mem_* held, no acknowledgement; completion occurs in the first cycle with clk_enable high.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: arbitrates a MIPS fetch port and a load/store port onto
// one shared memory bus. Three-state FSM (IDLE, GRANT_I, GRANT_D) with
// registered bus outputs, a 16-bit stall counter that aborts a transaction
// after TIMEOUT_CYCLES stalled cycles, and a sticky timeout flag.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin. Without it the data port always wins.
module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  // fetch port
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_waitrequest,
  // load/store port
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  // shared memory bus
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  // status
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  localparam logic [15:0] StallLimit = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] stall_cnt_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_writedata_q;
  logic [3:0]  mem_byteenable_q;
  logic        timeout_err_q;

  logic        instr_req;
  logic        data_req;
  logic        granted;
  logic        timeout_hit;
  logic        done;
  logic        pick_data;
  logic        issue_i_d;
  logic        issue_d_d;
  logic [31:0] resp_data;

  assign instr_req   = instr_read;
  assign data_req    = data_read | data_write;
  assign granted     = (state_q != IDLE);
  // The abort fires in the stalled cycle that brings the count to the limit.
  assign timeout_hit = granted && mem_waitrequest && (stall_cnt_q == StallLimit);
  // A completion is only acknowledged on an enabled cycle.
  assign done        = granted && clk_enable && (!mem_waitrequest || timeout_hit);
  assign resp_data   = timeout_hit ? 32'hFFFF_FFFF : mem_readdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant_q: 0 = fetch port granted last, 1 = data port granted last.
  logic last_grant_q;
  assign pick_data = data_req && (!instr_req || !last_grant_q);
`else
  assign pick_data = data_req;
`endif

  // Decide which port (if any) is issued onto the bus at the next edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    issue_i_d = 1'b0;
    issue_d_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clk_enable) begin
          issue_d_d = pick_data;
          issue_i_d = instr_req && !pick_data;
        end
      end
      GRANT_I: issue_d_d = done && data_req;
      GRANT_D: issue_i_d = done && instr_req;
      default: ;
    endcase
  end

  // FSM, stall counter, bus registers and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      stall_cnt_q      <= '0;
      mem_address_q    <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
      timeout_err_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q     <= 1'b0;
`endif
    end else if (clk_enable) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (issue_d_d) begin
        state_q          <= GRANT_D;
        stall_cnt_q      <= '0;
        mem_address_q    <= data_address;
        mem_read_q       <= data_read & ~data_write;
        mem_write_q      <= data_write;
        mem_writedata_q  <= data_writedata;
        mem_byteenable_q <= data_byteenable;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_q     <= 1'b1;
`endif
      end else if (issue_i_d) begin
        state_q          <= GRANT_I;
        stall_cnt_q      <= '0;
        mem_address_q    <= instr_address;
        mem_read_q       <= 1'b1;
        mem_write_q      <= 1'b0;
        mem_writedata_q  <= '0;
        mem_byteenable_q <= 4'hF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_q     <= 1'b0;
`endif
      end else if (done) begin
        state_q    <= IDLE;
        mem_read_q <= 1'b0;
        mem_write_q <= 1'b0;
      end else if (granted && mem_waitrequest) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign timeout_err    = timeout_err_q;
  assign busy           = granted;

  // Only the granted port sees memory data; a requesting port is released
  // only in its own completion cycle.
  assign instr_readdata    = (state_q == GRANT_I) ? resp_data : 32'h0;
  assign data_readdata     = (state_q == GRANT_D) ? resp_data : 32'h0;
  assign instr_waitrequest = instr_req && !((state_q == GRANT_I) && done);
  assign data_waitrequest  = data_req  && !((state_q == GRANT_D) && done);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter (TIMEOUT_CYCLES=4): vector table of single
// transactions, hand sequences for arbitration, timeout, async reset and
// clock-enable stalls, then randomized traffic against a reference model.
module tb_mips_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  mips_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_read = 0; instr_address = '0;
    data_read = 0; data_write = 0; data_address = '0;
    data_writedata = '0; data_byteenable = '0;
    mem_readdata = '0; mem_waitrequest = 0; clk_enable = 1;
  endtask

  // ---------------- reference model (transaction owner view) ----------------
  // owner: 0 = bus free, 1 = fetch port, 2 = data port
  int          m_owner, m_stalls, m_last;
  bit          m_terr, m_rd, m_wr, m_iack, m_dack;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_owner = 0; m_stalls = 0; m_last = 1; m_terr = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0; m_be = '0;
  endtask

  task automatic model_issue(input int p);
    m_owner = p; m_stalls = 0; m_last = p;
    if (p == 1) begin
      m_addr = instr_address; m_rd = 1; m_wr = 0; m_wd = '0; m_be = 4'hF;
    end else begin
      m_addr = data_address; m_wr = data_write; m_rd = data_read && !data_write;
      m_wd = data_writedata; m_be = data_byteenable;
    end
  endtask

  // Check all outputs for this cycle, then advance the model past the edge.
  task automatic model_cycle();
    bit ireq, dreq, tmo, done, dwin;
    logic [31:0] resp;
    ireq = instr_read;
    dreq = data_read || data_write;
    tmo  = (m_owner != 0) && mem_waitrequest && (m_stalls == TO - 1);
    done = (m_owner != 0) && clk_enable && (!mem_waitrequest || tmo);
    resp = tmo ? 32'hFFFF_FFFF : mem_readdata;
    m_iack = ireq && m_owner == 1 && done;
    m_dack = dreq && m_owner == 2 && done;
    check("rnd_busy", 32'(busy), 32'(m_owner != 0));
    check("rnd_terr", 32'(timeout_err), 32'(m_terr));
    check("rnd_iwait", 32'(instr_waitrequest), 32'(ireq && !m_iack));
    check("rnd_dwait", 32'(data_waitrequest), 32'(dreq && !m_dack));
    check("rnd_irdata", instr_readdata, (m_owner == 1) ? resp : 32'h0);
    check("rnd_drdata", data_readdata, (m_owner == 2) ? resp : 32'h0);
    check("rnd_maddr", mem_address, m_addr);
    check("rnd_mrd", 32'(mem_read), 32'(m_rd));
    check("rnd_mwr", 32'(mem_write), 32'(m_wr));
    check("rnd_mwd", mem_writedata, m_wd);
    check("rnd_mbe", 32'(mem_byteenable), 32'(m_be));
    if (!clk_enable) return;
    if (m_owner == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      dwin = dreq && (!ireq || m_last == 1);
`else
      dwin = dreq;
`endif
      if (dwin) model_issue(2);
      else if (ireq) model_issue(1);
    end else if (done) begin
      if (tmo) m_terr = 1;
      if (m_owner == 1 && dreq) model_issue(2);
      else if (m_owner == 2 && ireq) model_issue(1);
      else begin
        m_owner = 0; m_rd = 0; m_wr = 0;
      end
    end else if (mem_waitrequest) begin
      m_stalls++;
    end
  endtask

  // ---------------- single-transaction vector table ----------------
  typedef struct {
    bit          is_data;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          exp_rd;
    bit          exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vec_t v;
    logic pwait;
    logic [31:0] prd;
    bit i_pend, d_pend;

    vecs[0] = '{0, 1, 0, 32'hBFC0_0000, 32'h0,         4'h0,    32'h3C08_0001, 1, 0, 4'hF,    32'h0};
    vecs[1] = '{1, 1, 0, 32'h0000_2004, 32'hAAAA_AAAA, 4'b1111, 32'h1234_5678, 1, 0, 4'b1111, 32'hAAAA_AAAA};
    vecs[2] = '{1, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0000, 0, 1, 4'b0011, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1, 1, 32'h0000_3000, 32'h0BAD_F00D, 4'b1100, 32'h7777_0000, 0, 1, 4'b1100, 32'h0BAD_F00D};
    vecs[4] = '{0, 1, 0, 32'h0040_0010, 32'h0,         4'h0,    32'h2409_FFFF, 1, 0, 4'hF,    32'h0};

    // ---- reset state ----
    clear_inputs();
    reset = 1;
    #1 reset = 0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_mrd", 32'(mem_read), 0);
    check("rst_mwr", 32'(mem_write), 0);
    check("rst_maddr", mem_address, 0);
    check("rst_mwd", mem_writedata, 0);
    check("rst_mbe", 32'(mem_byteenable), 0);
    check("rst_terr", 32'(timeout_err), 0);
    tick();
    reset = 1;

    // ---- table: one transaction per vector, no stalls ----
    foreach (vecs[k]) begin
      v = vecs[k];
      tick();
      mem_readdata = v.rdata;
      if (v.is_data) begin
        data_read = v.rd; data_write = v.wr; data_address = v.addr;
        data_writedata = v.wd; data_byteenable = v.be;
      end else begin
        instr_read = 1; instr_address = v.addr;
      end
      @(negedge clk);
      pwait = v.is_data ? data_waitrequest : instr_waitrequest;
      check($sformatf("vec%0d_idle_busy", k), 32'(busy), 0);
      check($sformatf("vec%0d_idle_wait", k), 32'(pwait), 1);
      tick();
      @(negedge clk);
      pwait = v.is_data ? data_waitrequest : instr_waitrequest;
      prd   = v.is_data ? data_readdata : instr_readdata;
      check($sformatf("vec%0d_busy", k), 32'(busy), 1);
      check($sformatf("vec%0d_maddr", k), mem_address, v.addr);
      check($sformatf("vec%0d_mrd", k), 32'(mem_read), 32'(v.exp_rd));
      check($sformatf("vec%0d_mwr", k), 32'(mem_write), 32'(v.exp_wr));
      check($sformatf("vec%0d_mbe", k), 32'(mem_byteenable), 32'(v.exp_be));
      check($sformatf("vec%0d_mwd", k), mem_writedata, v.exp_wd);
      check($sformatf("vec%0d_wait", k), 32'(pwait), 0);
      check($sformatf("vec%0d_rdata", k), prd, v.rdata);
      check($sformatf("vec%0d_other_wait", k),
            32'(v.is_data ? instr_waitrequest : data_waitrequest), 0);
      check($sformatf("vec%0d_other_rdata", k),
            v.is_data ? instr_readdata : data_readdata, 0);
      tick();
      clear_inputs();
      @(negedge clk);
      check($sformatf("vec%0d_done_busy", k), 32'(busy), 0);
      check($sformatf("vec%0d_done_strobe", k), 32'({mem_read, mem_write}), 0);
    end

    // ---- simultaneous fetch and write: write first, fetch with no bubble ----
    tick();
    instr_read = 1; instr_address = 32'hBFC0_0000;
    data_write = 1; data_address = 32'h1000; data_writedata = 32'hDEAD_BEEF;
    data_byteenable = 4'b0011; mem_readdata = 32'h1111_2222;
    @(negedge clk);
    check("sim_idle_iwait", 32'(instr_waitrequest), 1);
    check("sim_idle_dwait", 32'(data_waitrequest), 1);
    tick();
    @(negedge clk);
    check("sim_d_mwr", 32'(mem_write), 1);
    check("sim_d_mbe", 32'(mem_byteenable), 32'(4'b0011));
    check("sim_d_maddr", mem_address, 32'h1000);
    check("sim_d_dwait", 32'(data_waitrequest), 0);
    check("sim_d_iwait", 32'(instr_waitrequest), 1);
    tick();
    data_write = 0;
    @(negedge clk);
    check("sim_i_busy", 32'(busy), 1);
    check("sim_i_mrd", 32'(mem_read), 1);
    check("sim_i_maddr", mem_address, 32'hBFC0_0000);
    check("sim_i_iwait", 32'(instr_waitrequest), 0);
    check("sim_i_rdata", instr_readdata, 32'h1111_2222);
    tick();
    clear_inputs();
    @(negedge clk);
    check("sim_end_busy", 32'(busy), 0);

    // ---- continuous requests on both ports: grants D,I,D,I,D,I ----
    tick();
    instr_read = 1; instr_address = 32'h0000_0400;
    data_write = 1; data_address = 32'h0000_0800; data_byteenable = 4'hF;
    tick();
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      check($sformatf("alt%0d_mwr", g), 32'(mem_write), 32'(g % 2 == 0));
      check($sformatf("alt%0d_mrd", g), 32'(mem_read), 32'(g % 2 == 1));
      check($sformatf("alt%0d_dwait", g), 32'(data_waitrequest), 32'(g % 2 == 1));
      check($sformatf("alt%0d_iwait", g), 32'(instr_waitrequest), 32'(g % 2 == 0));
      tick();
    end
    clear_inputs();
    tick();

    // ---- timeout: 4 stalled cycles abort the read ----
    data_read = 1; data_address = 32'h44; mem_waitrequest = 1;
    tick();
    for (int s = 1; s <= TO; s++) begin
      @(negedge clk);
      check($sformatf("to_stall%0d_dwait", s), 32'(data_waitrequest), 32'(s != TO));
      check($sformatf("to_stall%0d_terr", s), 32'(timeout_err), 0);
      if (s == TO) check("to_rdata", data_readdata, 32'hFFFF_FFFF);
      tick();
    end
    data_read = 0;
    @(negedge clk);
    check("to_terr_set", 32'(timeout_err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_mrd", 32'(mem_read), 0);
    mem_waitrequest = 0;
    tick(); tick();
    @(negedge clk);
    check("to_terr_sticky", 32'(timeout_err), 1);

    // ---- async reset mid-transaction, then first grant right after ----
    tick();
    data_write = 1; data_address = 32'h2000; data_writedata = 32'h5A5A_5A5A;
    data_byteenable = 4'hF; mem_waitrequest = 1;
    tick();
    @(negedge clk);
    check("ar_pre_mwr", 32'(mem_write), 1);
    #1 reset = 0;
    #1;
    check("ar_mwr", 32'(mem_write), 0);
    check("ar_mrd", 32'(mem_read), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_terr_clr", 32'(timeout_err), 0);
    check("ar_no_ack", 32'(data_waitrequest), 1);
    #1 reset = 1; mem_waitrequest = 0;
    @(negedge clk);
    check("ar_regrant_busy", 32'(busy), 1);
    check("ar_regrant_ack", 32'(data_waitrequest), 0);
    tick();
    clear_inputs();

    // ---- clk_enable low for 3 cycles during a grant ----
    instr_read = 1; instr_address = 32'h100; mem_readdata = 32'h55;
    tick();
    clk_enable = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("ce%0d_iwait", c), 32'(instr_waitrequest), 1);
      check($sformatf("ce%0d_mrd", c), 32'(mem_read), 1);
      check($sformatf("ce%0d_maddr", c), mem_address, 32'h100);
      tick();
    end
    clk_enable = 1;
    @(negedge clk);
    check("ce_ack", 32'(instr_waitrequest), 0);
    check("ce_rdata", instr_readdata, 32'h55);
    tick();
    clear_inputs();
    @(negedge clk);
    check("ce_end_busy", 32'(busy), 0);

    // ---- randomized traffic against the model ----
    tick();
    reset = 0;
    tick();
    reset = 1;
    model_reset();
    m_iack = 0; m_dack = 0; i_pend = 0; d_pend = 0;
    for (int n = 0; n < 600; n++) begin
      if (!i_pend || m_iack) begin
        i_pend = ($urandom_range(0, 9) < 4);
        instr_read = i_pend;
        instr_address = $urandom;
      end
      if (!d_pend || m_dack) begin
        d_pend = ($urandom_range(0, 9) < 4);
        data_read = d_pend && ($urandom_range(0, 2) != 0);
        data_write = d_pend && !data_read ? 1'b1 : (d_pend && $urandom_range(0, 3) == 0);
        data_address = $urandom;
        data_writedata = $urandom;
        data_byteenable = 4'($urandom);
      end
      clk_enable = ($urandom_range(0, 7) != 0);
      mem_waitrequest = ($urandom_range(0, 3) == 0);
      mem_readdata = $urandom;
      @(negedge clk);
      model_cycle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
